// File: rtl/parking_gate_ctrl.sv
// ---------------------------------------------------------------------------
// parking_gate_ctrl
//
// Turns the debounced entry/exit button levels into parking-lot actions.
// It detects the press edge of each level, keeps the occupancy count within
// 0..CAPACITY, opens the matching gate for GATE_CYCLES cycles per served
// event, and pulses reject for any press that cannot be served.
//
// Parameters:
//   CAPACITY     number of parking slots (1..15)
//   GATE_CYCLES  cycles a gate stays open per served event (1..255)
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst            synchronous active-high reset
//   i_enter_btn      debounced entry-button level
//   i_exit_btn       debounced exit-button level
//   o_count          current occupancy, 0..CAPACITY
//   o_full           occupancy == CAPACITY
//   o_empty          occupancy == 0
//   o_gate_in_open   entry gate open command
//   o_gate_out_open  exit gate open command
//   o_reject         one-cycle pulse: a press event was not served
// ---------------------------------------------------------------------------
module parking_gate_ctrl #(
    parameter int CAPACITY    = 8,
    parameter int GATE_CYCLES = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enter_btn,
    input  logic       i_exit_btn,
    output logic [3:0] o_count,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_gate_in_open,
    output logic       o_gate_out_open,
    output logic       o_reject
);

    localparam logic [3:0] CAP_V   = 4'(CAPACITY);
    localparam logic [7:0] T_RELOAD = 8'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ENTER_OPEN = 2'd1,
        EXIT_OPEN  = 2'd2
    } state_t;

    state_t     r_state,  w_state_nxt;
    logic [3:0] r_count,  w_count_nxt;
    logic [7:0] r_timer,  w_timer_nxt;
    logic       r_reject, w_reject_nxt;
    logic       r_enter_prev, r_exit_prev;

    logic w_enter_evt, w_exit_evt;
    logic w_full, w_empty;

    // Prev registers reset to 1 so a button held through reset release
    // cannot fire until it has been released and pressed again.
    assign w_enter_evt = i_enter_btn & ~r_enter_prev;
    assign w_exit_evt  = i_exit_btn  & ~r_exit_prev;

    assign w_full  = (r_count == CAP_V);
    assign w_empty = (r_count == 4'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_count      <= 4'd0;
            r_timer      <= 8'd0;
            r_reject     <= 1'b0;
            r_enter_prev <= 1'b1;
            r_exit_prev  <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_timer      <= w_timer_nxt;
            r_reject     <= w_reject_nxt;
            r_enter_prev <= i_enter_btn;
            r_exit_prev  <= i_exit_btn;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_timer_nxt  = r_timer;
        w_reject_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_exit_evt) begin
                    // Exit wins a simultaneous press; a concurrent entry is
                    // always dropped, and an unserved exit shares that one
                    // reject pulse.
                    if (!w_empty) begin
                        w_count_nxt  = r_count - 4'd1;
                        w_timer_nxt  = T_RELOAD;
                        w_state_nxt  = EXIT_OPEN;
                        w_reject_nxt = w_enter_evt;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end else if (w_enter_evt) begin
                    if (!w_full) begin
                        w_count_nxt = r_count + 4'd1;
                        w_timer_nxt = T_RELOAD;
                        w_state_nxt = ENTER_OPEN;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end
            end

            ENTER_OPEN, EXIT_OPEN: begin
                // Events are never queued while a gate is open.
                w_reject_nxt = w_enter_evt | w_exit_evt;
                if (r_timer == 8'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_timer_nxt = r_timer - 8'd1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_timer_nxt = 8'd0;
            end
        endcase
    end

    assign o_count         = r_count;
    assign o_full          = w_full;
    assign o_empty         = w_empty;
    assign o_gate_in_open  = (r_state == ENTER_OPEN);
    assign o_gate_out_open = (r_state == EXIT_OPEN);
    assign o_reject        = r_reject;

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Consumes the debounced entry and exit button levels produced by the debounce stage and turns them into parking-lot actions. It detects the press edge of each debounced level, maintains the lot occupancy count against a fixed capacity, and drives timed gate-open outputs. A reject pulse flags any press that cannot be served. Sits directly downstream of the two button debouncers and upstream of the display and gate-actuator logic.

## Interface

- CAPACITY, 8: number of parking slots; legal range 1..15.
- GATE_CYCLES, 20: cycles a gate stays open per served event; legal range 1..255.

- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enter_btn  input  1  debounced entry-button level (high while pressed).
- exit_btn  input  1  debounced exit-button level (high while pressed).
- count  output  4  current occupancy, 0..CAPACITY.
- full  output  1  high when count == CAPACITY.
- empty  output  1  high when count == 0.
- gate_in_open  output  1  entry gate open command.
- gate_out_open  output  1  exit gate open command.
- reject  output  1  one-cycle pulse: a press event was not served.

## Operation

- Edge detect: enter_prev/exit_prev registers sample the inputs every cycle. enter_evt = enter_btn & ~enter_prev; exit_evt likewise. Held levels produce exactly one event.
- The prev registers reset to 1, so a button held through reset release generates no event until it is released and pressed again.
- FSM states: IDLE, ENTER_OPEN, EXIT_OPEN. The 8-bit timer is used only in the open states.
- IDLE, exit_evt and !empty: count−1, timer←GATE_CYCLES−1, go to EXIT_OPEN.
- IDLE, exit_evt and empty: reject pulse, stay in IDLE.
- IDLE, enter_evt, no exit_evt, and !full: count+1, timer←GATE_CYCLES−1, go to ENTER_OPEN.
- IDLE, enter_evt and full: reject pulse, stay in IDLE.
- Simultaneous enter_evt and exit_evt in IDLE: exit has priority. Exit is served if !empty and the entry is dropped with a reject pulse. If empty, both are unserved and a single reject pulse is issued.
- ENTER_OPEN / EXIT_OPEN: the timer decrements each cycle. When the timer is 0, return to IDLE.
- Any event arriving in an open state is dropped with a reject pulse. Events are never queued.
- gate_in_open = (state == ENTER_OPEN); gate_out_open = (state == EXIT_OPEN). Both are registered-state decodes and are never high together.
- count never wraps. It cannot exceed CAPACITY or go below 0 by construction.
- full and empty are decodes of the count register.

## Timing

- Reset values: count=0, empty=1, full=0, gate_in_open=0, gate_out_open=0, reject=0, state=IDLE, timer=0, enter_prev=exit_prev=1.
- Event edge E is the first rising edge where the input samples 1 and prev holds 0.
- After E, count, full, empty and the gate output update together with one cycle of latency. reject is likewise registered, high for exactly the cycle after E.
- A gate output is high for exactly GATE_CYCLES cycles, from edge E to edge E+GATE_CYCLES. It is low after E+GATE_CYCLES.
- The earliest next servable event is at edge E+GATE_CYCLES+1.
- Reset mid-open: at the reset edge the gate drops and count clears to 0. An input held high across reset produces no event.

## Test plan

- Reset, then press enter_btn once, held 50 cycles -> count 0→1 one cycle after the edge, gate_in_open high exactly 20 cycles, single event only, reject stays 0.
- Eight separated entries with CAPACITY=8 -> count=8, full=1. A ninth press -> reject pulses once, count stays 8, gate_in_open stays 0.
- exit_btn pressed with count=0 -> reject pulses one cycle, empty stays 1, gate_out_open stays 0.
- count=3, enter_btn and exit_btn rise on the same cycle -> count=2, gate_out_open for 20 cycles, one reject pulse, gate_in_open stays 0.
- Entry served, then exit pressed 5 cycles later (gate still open) -> reject pulse, count unchanged. The same exit pressed after the gate closes -> served, count decrements.
- rst asserted at cycle 10 of ENTER_OPEN with enter_btn held -> gate_in_open=0 and count=0 after the reset edge. No new event after rst drops until enter_btn is released and pressed again.
